// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake with a one-entry skid buffer,
// flush with control-field masking, and saturating stall/bubble counters.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              cnt_clr,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,

    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic m_valid;
    logic accept;
    logic emit;

    assign m_valid = state_q[0];
    assign accept  = in_valid & in_ready_q;
    assign emit    = m_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    m_ctrl_d = in_ctrl;
                    m_data_d = in_data;
                end else if (accept) begin
                    state_d  = ST_FULL;
                    s_ctrl_d = in_ctrl;
                    s_data_d = in_data;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d  = ST_ONE;
                    m_ctrl_d = s_ctrl_q;
                    m_data_d = s_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A squash drops every entry but leaves the payload registers untouched,
        // so out_data keeps showing its last value while invalid.
        if (FLUSH) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = m_ctrl_q;
            m_data_d = m_data_q;
            s_ctrl_d = s_ctrl_q;
            s_data_d = s_data_q;
        end

        // Registered copy of !S.valid keeps in_ready free of combinational paths.
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (m_valid && !out_ready && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (!m_valid && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            // NOTE: the payload registers are reset too; out_data must read 0 after reset.
            m_ctrl_q     <= '0;
            m_data_q     <= '0;
            s_ctrl_q     <= '0;
            s_data_q     <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            m_ctrl_q     <= m_ctrl_d;
            m_data_q     <= m_data_d;
            s_ctrl_q     <= s_ctrl_d;
            s_data_q     <= s_data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = m_valid;
    assign out_ctrl   = m_valid ? m_ctrl_q : '0;
    assign out_data   = m_data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a random run, both scored
// against a two-deep queue model of the stage.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 64;
    localparam int MAX16  = 65535;
    localparam int MAX4   = 15;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              cnt_clr = 1'b0;
    logic              in_valid = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              in_ready, in_ready4;
    logic              out_valid, out_valid4;
    logic [CTRL_W-1:0] out_ctrl, out_ctrl4;
    logic [DATA_W-1:0] out_data, out_data4;
    logic [15:0]       stall_cnt, bubble_cnt;
    logic [3:0]        stall_cnt4, bubble_cnt4;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    entry_t            q[$];
    logic [DATA_W-1:0] last_data = '0;
    int exp_stall = 0, exp_bubble = 0, exp_stall4 = 0, exp_bubble4 = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .FLUSH(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .FLUSH(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
        .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
    );

    function automatic logic [CTRL_W-1:0] exp_ctrl();
        return (q.size() > 0) ? q[0].ctrl : '0;
    endfunction

    // Advance one clock; the model steps using the inputs held across the edge.
    task automatic tick();
        bit     acc, emi, st_inc, bub_inc;
        entry_t e;
        acc     = in_valid && (q.size() < 2);
        emi     = (q.size() > 0) && out_ready;
        st_inc  = (q.size() > 0) && !out_ready;
        bub_inc = (q.size() == 0);
        e.ctrl  = in_ctrl;
        e.data  = in_data;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            last_data = '0;
            exp_stall = 0; exp_bubble = 0; exp_stall4 = 0; exp_bubble4 = 0;
        end else begin
            if (flush) q.delete();
            else begin
                if (emi) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (q.size() > 0) last_data = q[0].data;
            if (cnt_clr) begin
                exp_stall = 0; exp_bubble = 0; exp_stall4 = 0; exp_bubble4 = 0;
            end else begin
                if (st_inc && exp_stall < MAX16)   exp_stall++;
                if (st_inc && exp_stall4 < MAX4)   exp_stall4++;
                if (bub_inc && exp_bubble < MAX16) exp_bubble++;
                if (bub_inc && exp_bubble4 < MAX4) exp_bubble4++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (5) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin failures++; $display("FAIL reset_out_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (bubble_cnt !== 16'd5) begin failures++; $display("FAIL reset_bubble_cnt: got %0d expected 5", bubble_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (bubble_cnt4 !== 4'd5) begin failures++; $display("FAIL reset_bubble_cnt4: got %0d expected 5", bubble_cnt4); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'hA5;
            in_data  = 64'(i);
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, out_valid); end
            checks++; if (out_data !== 64'(i)) begin failures++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, out_data, i); end
            checks++; if (out_ctrl !== 8'hA5) begin failures++; $display("FAIL stream_ctrl[%0d]: got %0h expected a5", i, out_ctrl); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid: got %0b expected 0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin failures++; $display("FAIL stream_drain_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (out_data !== 64'd10) begin failures++; $display("FAIL stream_hold_data: got %0h expected a", out_data); end
    endtask

    task automatic test_skid();
        in_ctrl = 8'h3C;
        in_valid = 1'b1; in_data = 64'd1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_data = 64'd2;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_full_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_data !== 64'd1) begin failures++; $display("FAIL skid_full_data: got %0h expected 1", out_data); end
        in_data = 64'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_hold_in_ready[%0d]: got %0b expected 0", i, in_ready); end
            checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL skid_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_stall); end
            checks++; if (out_data !== 64'd1) begin failures++; $display("FAIL skid_hold_data[%0d]: got %0h expected 1", i, out_data); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 64'd2) begin failures++; $display("FAIL skid_release_2: got %0h expected 2", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_release_in_ready: got %0b expected 1", in_ready); end
        tick();
        checks++; if (out_data !== 64'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL skid_release_3: got %0h/%0b expected 3/1", out_data, out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_drained: got %0b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        in_ctrl = 8'h77; out_ready = 1'b0; in_valid = 1'b1;
        in_data = 64'd7; tick();
        in_data = 64'd8; tick();
        checks++; if (in_ready !== 1'b0 || out_data !== 64'd7) begin failures++; $display("FAIL flush_setup: got ready=%0b data=%0h expected 0/7", in_ready, out_data); end
        flush = 1'b1; in_data = 64'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin failures++; $display("FAIL flush_out_ctrl: got %0h expected 0", out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_data !== 64'd7) begin failures++; $display("FAIL flush_hold_data: got %0h expected 7", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost[%0d]: got %0b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_saturation();
        in_valid = 1'b1; in_data = 64'hABCD; in_ctrl = 8'h11; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (stall_cnt4 !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt4: got %0d expected 15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL sat_stall_cnt16: got %0d expected %0d", stall_cnt, exp_stall); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if (stall_cnt4 !== 4'd0 || bubble_cnt4 !== 4'd0) begin failures++; $display("FAIL clr_cnt4: got %0d/%0d expected 0/0", stall_cnt4, bubble_cnt4); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL clr_cnt16: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
        tick();
        checks++; if (stall_cnt4 !== 4'd1) begin failures++; $display("FAIL clr_resume_cnt4: got %0d expected 1", stall_cnt4); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hEE;
        in_data = 64'h55; tick();
        in_data = 64'h66; tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_handshake: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
        checks++; if (out_data !== 64'h0 || out_ctrl !== 8'h0) begin failures++; $display("FAIL midrst_payload: got %0h/%0h expected 0/0", out_data, out_ctrl); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin failures++; $display("FAIL midrst_counters: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin failures++; $display("FAIL midrst_no_ghost: got valid=%0b bubble=%0d expected 0/1", out_valid, bubble_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 2);
            cnt_clr   = ($urandom_range(0, 999) < 5);
            in_ctrl   = CTRL_W'($urandom());
            in_data   = {$urandom(), $urandom()};
            tick();
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_in_ready[%0d]: got %0b expected %0b", i, in_ready, q.size() < 2); end
            checks++; if (out_ctrl !== exp_ctrl()) begin failures++; $display("FAIL rnd_ctrl[%0d]: got %0h expected %0h", i, out_ctrl, exp_ctrl()); end
            checks++; if (out_data !== last_data) begin failures++; $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, out_data, last_data); end
            checks++; if (stall_cnt !== 16'(exp_stall) || bubble_cnt !== 16'(exp_bubble)) begin failures++; $display("FAIL rnd_cnt16[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt, bubble_cnt, exp_stall, exp_bubble); end
            checks++; if (stall_cnt4 !== 4'(exp_stall4) || bubble_cnt4 !== 4'(exp_bubble4)) begin failures++; $display("FAIL rnd_cnt4[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt4, bubble_cnt4, exp_stall4, exp_bubble4); end
        end
        flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
